// File: rtl/lsb_pkg.sv
// Shared definitions for the load/store buffer: widths, funct3 encodings,
// request FSM states and the I/O address decode.
package lsb_pkg;

  localparam int ROB_W     = 4;
  localparam int LSB_W     = 3;
  localparam int STORE_BIT = 3;

  // Stores reuse the byte/half/word codes: SB=F3_B, SH=F3_H, SW=F3_W.
  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  function automatic logic is_io_addr(input logic [31:0] addr);
    return addr[17:16] == 2'b11;
  endfunction

endpackage

// File: rtl/lsb_if.sv
// Bundle of decoder issue, CDB, ROB head, memctrl and result-broadcast signals
// seen by the load/store buffer; slave is the buffer, master its environment.
interface lsb_if #(
  parameter int ROB_WIDTH = lsb_pkg::ROB_W
);
  logic                 lsb_issue_ready;
  logic [3:0]           lsb_type;
  logic [31:0]          lsb_val_j, lsb_val_k, lsb_imm;
  logic                 lsb_has_dep_j, lsb_has_dep_k;
  logic [ROB_WIDTH-1:0] lsb_dep_j, lsb_dep_k, lsb_rob_id;
  logic                 lsb_full;
  logic                 cdb_valid;
  logic [ROB_WIDTH-1:0] cdb_rob_id;
  logic [31:0]          cdb_val;
  logic                 rob_head_valid;
  logic [ROB_WIDTH-1:0] rob_head_id;
  logic                 ls_enable, is_write;
  logic [31:0]          ls_addr, store_val;
  logic [3:0]           ls_type;
  logic                 ls_finished;
  logic [31:0]          load_val;
  logic                 lsb_ready;
  logic [ROB_WIDTH-1:0] lsb_out_rob_id;
  logic [31:0]          lsb_out_val;

  modport slave (
    input  lsb_issue_ready, lsb_type, lsb_val_j, lsb_val_k, lsb_imm,
           lsb_has_dep_j, lsb_has_dep_k, lsb_dep_j, lsb_dep_k, lsb_rob_id,
           cdb_valid, cdb_rob_id, cdb_val, rob_head_valid, rob_head_id,
           ls_finished, load_val,
    output lsb_full, ls_enable, is_write, ls_addr, store_val, ls_type,
           lsb_ready, lsb_out_rob_id, lsb_out_val
  );

  modport master (
    output lsb_issue_ready, lsb_type, lsb_val_j, lsb_val_k, lsb_imm,
           lsb_has_dep_j, lsb_has_dep_k, lsb_dep_j, lsb_dep_k, lsb_rob_id,
           cdb_valid, cdb_rob_id, cdb_val, rob_head_valid, rob_head_id,
           ls_finished, load_val,
    input  lsb_full, ls_enable, is_write, ls_addr, store_val, ls_type,
           lsb_ready, lsb_out_rob_id, lsb_out_val
  );
endinterface

// File: rtl/load_ext.sv
// Sign/zero extension of raw (zero-extended) memory data according to the
// load funct3.
module load_ext
  import lsb_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [31:0] raw_i,
  output logic [31:0] ext_o
);

  always_comb begin
    // NOTE: default assignment first so every path drives ext_o and no latch is inferred.
    ext_o = raw_i;
    case (funct3_i)
      F3_B:    ext_o = {{24{raw_i[7]}}, raw_i[7:0]};
      F3_H:    ext_o = {{16{raw_i[15]}}, raw_i[15:0]};
      F3_BU:   ext_o = {24'b0, raw_i[7:0]};
      F3_HU:   ext_o = {16'b0, raw_i[15:0]};
      default: ext_o = raw_i;
    endcase
  end

endmodule

// File: rtl/lsb.sv
// In-order load/store buffer: circular entry queue with CDB wakeup and a
// two-state request machine issuing one memctrl access at a time.
module lsb
  import lsb_pkg::*;
#(
  parameter int LSB_WIDTH = LSB_W,
  parameter int ROB_WIDTH = ROB_W
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic rdy_in,
  input  logic clear,
  lsb_if.slave bus
);

  localparam int DEPTH = 1 << LSB_WIDTH;
  localparam logic [LSB_WIDTH:0] FULL_CNT = (LSB_WIDTH + 1)'(DEPTH);

  typedef logic [LSB_WIDTH-1:0] ptr_t;
  typedef logic [ROB_WIDTH-1:0] tag_t;

  logic [DEPTH-1:0] valid_q, dep_j_q, dep_k_q;
  logic [3:0]       type_q   [DEPTH];
  logic [31:0]      val_j_q  [DEPTH];
  logic [31:0]      val_k_q  [DEPTH];
  logic [31:0]      imm_q    [DEPTH];
  tag_t             tag_j_q  [DEPTH];
  tag_t             tag_k_q  [DEPTH];
  tag_t             rob_id_q [DEPTH];

  ptr_t               head_q, head_d, tail_q, tail_d;
  logic [LSB_WIDTH:0] count_q, count_d;
  logic [0:0]         state_q, state_d;

  logic        ls_enable_q, is_write_q, lsb_ready_q;
  logic [31:0] ls_addr_q, store_val_q, out_val_q;
  logic [3:0]  ls_type_q;
  tag_t        out_rob_id_q;

  logic        cdb_v;
  tag_t        cdb_tag;
  logic [31:0] cdb_data, head_addr, ext_val;
  logic        full, enq, deq, head_ok, head_fire;

  assign cdb_v    = bus.cdb_valid;
  assign cdb_tag  = bus.cdb_rob_id;
  assign cdb_data = bus.cdb_val;

  // Both the CDB and our own result broadcast wake waiting operands.
  function automatic logic wake_hit(input tag_t tag);
    return (cdb_v && cdb_tag == tag) || (lsb_ready_q && out_rob_id_q == tag);
  endfunction

  function automatic logic [31:0] wake_val(input tag_t tag);
    return (cdb_v && cdb_tag == tag) ? cdb_data : out_val_q;
  endfunction

  assign head_addr = val_j_q[head_q] + imm_q[head_q];
  assign head_ok   = valid_q[head_q] && !dep_j_q[head_q] && !dep_k_q[head_q];
  // Stores and I/O loads must wait until they are the oldest ROB entry.
  assign head_fire = (state_q == ST_IDLE) && head_ok &&
                     ((!type_q[head_q][STORE_BIT] && !is_io_addr(head_addr)) ||
                      (bus.rob_head_valid && bus.rob_head_id == rob_id_q[head_q]));
  assign deq  = (state_q == ST_WAIT) && bus.ls_finished && !clear;
  assign full = (count_q == FULL_CNT);
  assign enq  = bus.lsb_issue_ready && (!full || deq) && !clear;

  always_comb begin
    head_d  = deq ? head_q + ptr_t'(1) : head_q;
    tail_d  = enq ? tail_q + ptr_t'(1) : tail_q;
    count_d = count_q + (LSB_WIDTH + 1)'(enq) - (LSB_WIDTH + 1)'(deq);
    state_d = state_q;
    if (head_fire)  state_d = ST_WAIT;
    else if (deq)   state_d = ST_IDLE;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_q <= '0;
      dep_j_q <= '0;
      dep_k_q <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        valid_q <= '0;
      end else begin
        // NOTE: non-blocking updates; the later issue write deliberately overrides the dequeue.
        for (int i = 0; i < DEPTH; i++) begin
          if (dep_j_q[i] && wake_hit(tag_j_q[i])) dep_j_q[i] <= 1'b0;
          if (dep_k_q[i] && wake_hit(tag_k_q[i])) dep_k_q[i] <= 1'b0;
        end
        if (deq) valid_q[head_q] <= 1'b0;
        if (enq) begin
          valid_q[tail_q] <= 1'b1;
          dep_j_q[tail_q] <= bus.lsb_has_dep_j && !wake_hit(bus.lsb_dep_j);
          dep_k_q[tail_q] <= bus.lsb_has_dep_k && !wake_hit(bus.lsb_dep_k);
        end
      end
    end
  end

  // NOTE: entry payload has no reset; it is only read while its valid bit is set.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (dep_j_q[i] && wake_hit(tag_j_q[i])) val_j_q[i] <= wake_val(tag_j_q[i]);
        if (dep_k_q[i] && wake_hit(tag_k_q[i])) val_k_q[i] <= wake_val(tag_k_q[i]);
      end
      if (enq) begin
        type_q[tail_q]   <= bus.lsb_type;
        imm_q[tail_q]    <= bus.lsb_imm;
        tag_j_q[tail_q]  <= bus.lsb_dep_j;
        tag_k_q[tail_q]  <= bus.lsb_dep_k;
        rob_id_q[tail_q] <= bus.lsb_rob_id;
        val_j_q[tail_q]  <= (bus.lsb_has_dep_j && wake_hit(bus.lsb_dep_j)) ?
                            wake_val(bus.lsb_dep_j) : bus.lsb_val_j;
        val_k_q[tail_q]  <= (bus.lsb_has_dep_k && wake_hit(bus.lsb_dep_k)) ?
                            wake_val(bus.lsb_dep_k) : bus.lsb_val_k;
      end
    end
  end

  load_ext u_load_ext (
    .funct3_i (ls_type_q[2:0]),
    .raw_i    (bus.load_val),
    .ext_o    (ext_val)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      state_q      <= ST_IDLE;
      ls_enable_q  <= 1'b0;
      is_write_q   <= 1'b0;
      ls_addr_q    <= '0;
      store_val_q  <= '0;
      ls_type_q    <= '0;
      lsb_ready_q  <= 1'b0;
      out_rob_id_q <= '0;
      out_val_q    <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        head_q      <= '0;
        tail_q      <= '0;
        count_q     <= '0;
        state_q     <= ST_IDLE;
        ls_enable_q <= 1'b0;
        lsb_ready_q <= 1'b0;
      end else begin
        head_q      <= head_d;
        tail_q      <= tail_d;
        count_q     <= count_d;
        state_q     <= state_d;
        lsb_ready_q <= deq;
        if (head_fire) begin
          ls_enable_q <= 1'b1;
          ls_addr_q   <= head_addr;
          store_val_q <= val_k_q[head_q];
          is_write_q  <= type_q[head_q][STORE_BIT];
          ls_type_q   <= type_q[head_q];
        end else if (deq) begin
          ls_enable_q <= 1'b0;
        end
        if (deq) begin
          out_rob_id_q <= rob_id_q[head_q];
          out_val_q    <= is_write_q ? 32'b0 : ext_val;
        end
      end
    end
  end

  assign bus.lsb_full       = full;
  assign bus.ls_enable      = ls_enable_q;
  assign bus.is_write       = is_write_q;
  assign bus.ls_addr        = ls_addr_q;
  assign bus.store_val      = store_val_q;
  assign bus.ls_type        = ls_type_q;
  assign bus.lsb_ready      = lsb_ready_q;
  assign bus.lsb_out_rob_id = out_rob_id_q;
  assign bus.lsb_out_val    = out_val_q;

endmodule

// File: tb/tb_lsb.sv
// Directed and randomized bench for the load/store buffer, with a memctrl
// responder and an arithmetic load-extension reference.
module tb_lsb;
  import lsb_pkg::*;

  localparam int RW = ROB_W;

  typedef struct {
    logic [3:0]    typ;
    logic [31:0]   addr;
    logic [31:0]   vk;
  } req_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy = 1'b1;
  logic clr = 1'b0;
  int   total = 0;
  int   bad = 0;
  req_t mq [8];
  logic [2:0] load_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  lsb_if #(.ROB_WIDTH(RW)) bus ();

  lsb #(.LSB_WIDTH(LSB_W), .ROB_WIDTH(RW)) u_dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .rdy_in (rdy),
    .clear  (clr),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.lsb_issue_ready = 1'b0; bus.lsb_type = '0;
    bus.lsb_val_j = '0; bus.lsb_val_k = '0; bus.lsb_imm = '0;
    bus.lsb_has_dep_j = 1'b0; bus.lsb_has_dep_k = 1'b0;
    bus.lsb_dep_j = '0; bus.lsb_dep_k = '0; bus.lsb_rob_id = '0;
    bus.cdb_valid = 1'b0; bus.cdb_rob_id = '0; bus.cdb_val = '0;
    bus.rob_head_valid = 1'b0; bus.rob_head_id = '0;
    bus.ls_finished = 1'b0; bus.load_val = '0;
  endtask

  task automatic set_issue(input logic [3:0] typ, input logic [31:0] vj, input logic [31:0] vk,
                           input logic [31:0] imm, input logic hj, input logic hk,
                           input logic [RW-1:0] dj, input logic [RW-1:0] dk,
                           input logic [RW-1:0] rid);
    bus.lsb_issue_ready = 1'b1; bus.lsb_type = typ;
    bus.lsb_val_j = vj; bus.lsb_val_k = vk; bus.lsb_imm = imm;
    bus.lsb_has_dep_j = hj; bus.lsb_has_dep_k = hk;
    bus.lsb_dep_j = dj; bus.lsb_dep_k = dk; bus.lsb_rob_id = rid;
  endtask

  task automatic issue(input logic [3:0] typ, input logic [31:0] vj, input logic [31:0] vk,
                       input logic [31:0] imm, input logic hj, input logic hk,
                       input logic [RW-1:0] dj, input logic [RW-1:0] dk,
                       input logic [RW-1:0] rid);
    set_issue(typ, vj, vk, imm, hj, hk, dj, dk, rid);
    tick();
    bus.lsb_issue_ready = 1'b0; bus.lsb_has_dep_j = 1'b0; bus.lsb_has_dep_k = 1'b0;
  endtask

  task automatic expect_req(input string tag, input logic [31:0] addr, input logic w,
                            input logic [31:0] sv, input logic [3:0] typ);
    int n = 0;
    while (bus.ls_enable !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, ".en"}, 32'(bus.ls_enable), 32'd1);
    check({tag, ".addr"}, bus.ls_addr, addr);
    check({tag, ".wr"}, 32'(bus.is_write), 32'(w));
    check({tag, ".sval"}, bus.store_val, sv);
    check({tag, ".type"}, 32'(bus.ls_type), 32'(typ));
  endtask

  task automatic expect_no_req(input string tag, input int cycles);
    logic seen = 1'b0;
    repeat (cycles) begin
      tick();
      if (bus.ls_enable !== 1'b0) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  task automatic complete(input string tag, input logic [31:0] raw,
                          input logic [RW-1:0] rid, input logic [31:0] oval);
    bus.ls_finished = 1'b1; bus.load_val = raw;
    tick();
    bus.ls_finished = 1'b0; bus.load_val = $urandom;
    check({tag, ".rdy"}, 32'(bus.lsb_ready), 32'd1);
    check({tag, ".rid"}, 32'(bus.lsb_out_rob_id), 32'(rid));
    check({tag, ".oval"}, bus.lsb_out_val, oval);
    check({tag, ".endrop"}, 32'(bus.ls_enable), 32'd0);
    tick();
    check({tag, ".pulse"}, 32'(bus.lsb_ready), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".full"}, 32'(bus.lsb_full), 32'd0);
    check({tag, ".en"}, 32'(bus.ls_enable), 32'd0);
    check({tag, ".wr"}, 32'(bus.is_write), 32'd0);
    check({tag, ".addr"}, bus.ls_addr, 32'd0);
    check({tag, ".sval"}, bus.store_val, 32'd0);
    check({tag, ".type"}, 32'(bus.ls_type), 32'd0);
    check({tag, ".rdy"}, 32'(bus.lsb_ready), 32'd0);
    check({tag, ".rid"}, 32'(bus.lsb_out_rob_id), 32'd0);
    check({tag, ".oval"}, bus.lsb_out_val, 32'd0);
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] raw);
    longint v;
    case (f3)
      3'b000:  begin v = longint'(raw % 256);   if (v > 127)   v = v - 256;   end
      3'b001:  begin v = longint'(raw % 65536); if (v > 32767) v = v - 65536; end
      3'b100:  v = longint'(raw % 256);
      3'b101:  v = longint'(raw % 65536);
      default: v = longint'(raw);
    endcase
    return 32'(v);
  endfunction

  function automatic logic [31:0] mem_raw(input logic [31:0] addr, input logic [2:0] f3);
    logic [31:0] word = addr * 32'h9E37_79B1 + 32'h0123_4567;
    case (f3[1:0])
      2'b00:   return word % 256;
      2'b01:   return word % 65536;
      default: return word;
    endcase
  endfunction

  initial begin
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst0");
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Byte loads with negative offset: signed and unsigned extension.
    issue(4'b0000, 32'h1000, 32'h0, 32'hFFFF_FFFC, 1'b0, 1'b0, '0, '0, 4'd1);
    expect_req("lb", 32'h0000_0FFC, 1'b0, 32'h0, 4'b0000);
    complete("lb", 32'h80, 4'd1, 32'hFFFF_FF80);
    issue(4'b0100, 32'h1000, 32'h0, 32'hFFFF_FFFC, 1'b0, 1'b0, '0, '0, 4'd1);
    expect_req("lbu", 32'h0000_0FFC, 1'b0, 32'h0, 4'b0100);
    complete("lbu", 32'h80, 4'd1, 32'h0000_0080);

    // Wakeup from the CDB in the issue cycle itself.
    bus.cdb_valid = 1'b1; bus.cdb_rob_id = 4'd9; bus.cdb_val = 32'h2000;
    issue(4'b0010, 32'hBAD0, 32'h0, 32'h4, 1'b1, 1'b0, 4'd9, '0, 4'd2);
    bus.cdb_valid = 1'b0;
    expect_req("issue_wake", 32'h2004, 1'b0, 32'h0, 4'b0010);
    complete("issue_wake", 32'h1122_3344, 4'd2, 32'h1122_3344);

    // Wakeup from the buffer's own result broadcast.
    issue(4'b0010, 32'h40, 32'h0, 32'h0, 1'b0, 1'b0, '0, '0, 4'd3);
    issue(4'b0010, 32'hDEAD, 32'h0, 32'h8, 1'b1, 1'b0, 4'd3, '0, 4'd4);
    expect_req("self_a", 32'h40, 1'b0, 32'h0, 4'b0010);
    complete("self_a", 32'h500, 4'd3, 32'h500);
    expect_req("self_b", 32'h508, 1'b0, 32'h0, 4'b0010);
    complete("self_b", 32'h0, 4'd4, 32'h0);

    // Store waits for data and for its ROB head turn.
    bus.rob_head_valid = 1'b1; bus.rob_head_id = 4'd2;
    issue(4'b1010, 32'h400, 32'h0, 32'h10, 1'b0, 1'b1, '0, 4'd5, 4'd6);
    expect_no_req("sw_nodata", 3);
    bus.cdb_valid = 1'b1; bus.cdb_rob_id = 4'd5; bus.cdb_val = 32'hDEAD_BEEF;
    tick();
    bus.cdb_valid = 1'b0;
    expect_no_req("sw_nohead", 4);
    bus.rob_head_id = 4'd6;
    expect_req("sw", 32'h410, 1'b1, 32'hDEAD_BEEF, 4'b1010);
    complete("sw", 32'h1234_5678, 4'd6, 32'h0);

    // I/O load waits for the ROB head.
    bus.rob_head_id = 4'd3;
    issue(4'b0010, 32'h0003_0000, 32'h0, 32'h0, 1'b0, 1'b0, '0, '0, 4'd7);
    expect_no_req("io_hold", 4);
    bus.rob_head_id = 4'd7;
    expect_req("io", 32'h0003_0000, 1'b0, 32'h0, 4'b0010);
    complete("io", 32'hCAFE_F00D, 4'd7, 32'hCAFE_F00D);

    // Full buffer, simultaneous dequeue and issue.
    bus.rob_head_id = 4'd0;
    for (int i = 0; i < 8; i++) begin
      check("fill.notfull", 32'(bus.lsb_full), 32'd0);
      issue(4'b1010, 32'h1000 + 32'(16 * i), 32'(i), 32'h0, 1'b0, 1'b0, '0, '0, 4'(8 + i));
    end
    check("fill.full", 32'(bus.lsb_full), 32'd1);
    bus.rob_head_id = 4'd8;
    expect_req("full_a", 32'h1000, 1'b1, 32'h0, 4'b1010);
    check("full_a.full", 32'(bus.lsb_full), 32'd1);
    set_issue(4'b1010, 32'h2000, 32'h77, 32'h0, 1'b0, 1'b0, '0, '0, 4'd0);
    bus.ls_finished = 1'b1;
    tick();
    bus.ls_finished = 1'b0; bus.lsb_issue_ready = 1'b0;
    check("swap.full", 32'(bus.lsb_full), 32'd1);
    check("swap.rdy", 32'(bus.lsb_ready), 32'd1);
    check("swap.rid", 32'(bus.lsb_out_rob_id), 32'd8);
    tick();
    check("swap.full2", 32'(bus.lsb_full), 32'd1);
    bus.rob_head_id = 4'd9;
    expect_req("full_b", 32'h1010, 1'b1, 32'h1, 4'b1010);
    complete("full_b", 32'h0, 4'd9, 32'h0);
    check("drain.full", 32'(bus.lsb_full), 32'd0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr1.full", 32'(bus.lsb_full), 32'd0);
    bus.rob_head_valid = 1'b0;

    // Clear during WAIT with a coincident completion.
    issue(4'b0010, 32'h200, 32'h0, 32'h0, 1'b0, 1'b0, '0, '0, 4'd1);
    expect_req("clrw", 32'h200, 1'b0, 32'h0, 4'b0010);
    clr = 1'b1; bus.ls_finished = 1'b1;
    tick();
    clr = 1'b0; bus.ls_finished = 1'b0;
    check("clrw.en", 32'(bus.ls_enable), 32'd0);
    check("clrw.rdy", 32'(bus.lsb_ready), 32'd0);
    check("clrw.full", 32'(bus.lsb_full), 32'd0);
    tick();
    check("clrw.rdy2", 32'(bus.lsb_ready), 32'd0);
    issue(4'b0010, 32'h240, 32'h0, 32'h0, 1'b0, 1'b0, '0, '0, 4'd2);
    expect_req("after_clr", 32'h240, 1'b0, 32'h0, 4'b0010);
    complete("after_clr", 32'h55, 4'd2, 32'h55);

    // Asynchronous reset in the middle of an access.
    issue(4'b0010, 32'h300, 32'h0, 32'h0, 1'b0, 1'b0, '0, '0, 4'd3);
    expect_req("rstw", 32'h300, 1'b0, 32'h0, 4'b0010);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rstw");
    @(negedge clk) rst_n = 1'b1;
    tick();
    issue(4'b0010, 32'h100, 32'h0, 32'h0, 1'b0, 1'b0, '0, '0, 4'd4);
    expect_req("post_rst", 32'h100, 1'b0, 32'h0, 4'b0010);
    complete("post_rst", 32'h9, 4'd4, 32'h9);

    // Randomized batches: ROB ids 0..7 for entries, producer tags 8..15.
    for (int b = 0; b < 12; b++) begin
      int k = int'($urandom_range(1, 8));
      logic [7:0] has_dep = '0;
      logic [31:0] prod [8];
      for (int i = 0; i < k; i++) begin
        logic st = ($urandom_range(0, 2) == 0);
        logic [2:0] f3 = st ? 3'($urandom_range(0, 2)) : load_f3[$urandom_range(0, 4)];
        logic hj = ($urandom_range(0, 3) == 0);
        logic hk = ($urandom_range(0, 3) == 0);
        int ii = int'($urandom_range(0, 4095)) - 2048;
        logic [31:0] imm = 32'(ii);
        logic [31:0] base = $urandom;
        logic [31:0] vk;
        logic [31:0] addr = base + imm;
        if (!st && addr[17:16] == 2'b11) base = base ^ 32'h0002_0000;
        addr = base + imm;
        vk = hk ? base : $urandom;
        prod[i] = base;
        has_dep[i] = hj || hk;
        mq[i].typ = {st, f3}; mq[i].addr = addr; mq[i].vk = vk;
        issue({st, f3}, hj ? $urandom : base, hk ? $urandom : vk, imm, hj, hk,
              4'(8 + i), 4'(8 + i), 4'(i));
      end
      for (int i = k - 1; i >= 0; i--) begin
        if (has_dep[i]) begin
          bus.cdb_valid = 1'b1; bus.cdb_rob_id = 4'(8 + i); bus.cdb_val = prod[i];
          tick();
          bus.cdb_valid = 1'b0;
          repeat ($urandom_range(0, 2)) tick();
        end
      end
      for (int i = 0; i < k; i++) begin
        logic st = mq[i].typ[3];
        logic [31:0] raw = st ? $urandom : mem_raw(mq[i].addr, mq[i].typ[2:0]);
        if (st) begin
          bus.rob_head_valid = 1'b1; bus.rob_head_id = 4'(i);
        end
        expect_req("rnd", mq[i].addr, st, mq[i].vk, mq[i].typ);
        complete("rnd", raw, 4'(i), st ? 32'h0 : ref_load(mq[i].typ[2:0], raw));
        bus.rob_head_valid = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
